// File: rtl/fan_pwm_driver_pkg.sv
// Shared types and default constants for the fan PWM driver and its channels.
package fan_pwm_driver_pkg;

  localparam int unsigned PwmPeriodDef  = 1000;
  localparam int unsigned DutyWDef      = 11;
  localparam int unsigned RpmMaxDef     = 10000;
  localparam int unsigned DutyMulDef    = 6554;
  localparam int unsigned SlewMaxDef    = 50;
  localparam int unsigned ArmDutyDef    = 50;
  localparam int unsigned ArmPeriodsDef = 4;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StArming = 2'd1,
    StRun    = 2'd2
  } fan_state_e;

endpackage

// File: rtl/fan_pwm_channel.sv
// One fan channel: saturation, RPM-to-duty scaling, per-period slew limit and the
// registered PWM compare. Duty and SAT only change on the period tick.
module fan_pwm_channel
  import fan_pwm_driver_pkg::*;
#(
  parameter int unsigned PwmPeriod = PwmPeriodDef,
  parameter int unsigned DutyW     = DutyWDef,
  parameter int unsigned RpmMax    = RpmMaxDef,
  parameter int unsigned DutyMul   = DutyMulDef,
  parameter int unsigned SlewMax   = SlewMaxDef,
  parameter int unsigned ArmDuty   = ArmDutyDef,
  parameter int unsigned CntW      = $clog2(PwmPeriod)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               tick_i,
  input  logic [CntW-1:0]    cnt_next_i,
  input  logic [1:0]         state_next_i,
  input  logic signed [31:0] pid_i,
  output logic [DutyW-1:0]   duty_o,
  output logic               sat_o,
  output logic               pwm_o
);

  localparam logic signed [31:0] RpmMaxS = 32'(RpmMax);

  logic [31:0]      sat_val;
  logic             clamp;
  logic [47:0]      prod;
  logic [31:0]      target_full;
  logic [DutyW-1:0] target, slewed;
  logic [DutyW-1:0] duty_d, duty_q;
  logic             sat_d, sat_q;
  logic             pwm_d, pwm_q;

  always_comb begin
    clamp   = 1'b0;
    sat_val = pid_i;
    if (pid_i < 0) begin
      clamp   = 1'b1;
      sat_val = '0;
    end else if (pid_i > RpmMaxS) begin
      clamp   = 1'b1;
      sat_val = 32'(RpmMax);
    end
  end

  assign prod        = {16'd0, sat_val} * 48'(DutyMul);
  assign target_full = prod[47:16];
  assign target      = (target_full > 32'(PwmPeriod)) ? DutyW'(PwmPeriod)
                                                      : target_full[DutyW-1:0];

  always_comb begin
    if (target > duty_q) begin
      slewed = ((target - duty_q) > DutyW'(SlewMax)) ? duty_q + DutyW'(SlewMax) : target;
    end else begin
      slewed = ((duty_q - target) > DutyW'(SlewMax)) ? duty_q - DutyW'(SlewMax) : target;
    end
  end

  always_comb begin
    duty_d = duty_q;
    sat_d  = sat_q;
    if (tick_i) begin
      sat_d = clamp;
      case (fan_state_e'(state_next_i))
        StIdle:   duty_d = '0;
        StArming: duty_d = DutyW'(ArmDuty);
        StRun:    duty_d = slewed;
        default:  duty_d = '0;
      endcase
    end
    // Compare against the duty of the period the next counter value belongs to.
    pwm_d = DutyW'(cnt_next_i) < duty_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      duty_q <= '0;
      sat_q  <= 1'b0;
      pwm_q  <= 1'b0;
    end else begin
      duty_q <= duty_d;
      sat_q  <= sat_d;
      pwm_q  <= pwm_d;
    end
  end

  assign duty_o = duty_q;
  assign sat_o  = sat_q;
  assign pwm_o  = pwm_q;

endmodule

// File: rtl/fan_pwm_driver.sv
// Four-fan PWM driver: shared period counter and arm/spin-up FSM feeding four
// channels. All duty and state updates land on the counter wrap.
module fan_pwm_driver
  import fan_pwm_driver_pkg::*;
#(
  parameter int unsigned PwmPeriod  = PwmPeriodDef,
  parameter int unsigned DutyW      = DutyWDef,
  parameter int unsigned RpmMax     = RpmMaxDef,
  parameter int unsigned DutyMul    = DutyMulDef,
  parameter int unsigned SlewMax    = SlewMaxDef,
  parameter int unsigned ArmDuty    = ArmDutyDef,
  parameter int unsigned ArmPeriods = ArmPeriodsDef
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               arm_i,
  input  logic signed [31:0] pid_out1_i,
  input  logic signed [31:0] pid_out2_i,
  input  logic signed [31:0] pid_out3_i,
  input  logic signed [31:0] pid_out4_i,
  output logic [3:0]         pwm_out_o,
  output logic [DutyW-1:0]   duty1_o,
  output logic [DutyW-1:0]   duty2_o,
  output logic [DutyW-1:0]   duty3_o,
  output logic [DutyW-1:0]   duty4_o,
  output logic [3:0]         sat_o,
  output logic [1:0]         state_o,
  output logic               period_tick_o
);

  localparam int unsigned      CntW    = $clog2(PwmPeriod);
  localparam int unsigned      ArmCntW = $clog2(ArmPeriods + 1);
  localparam logic [CntW-1:0]  CntLast = CntW'(PwmPeriod - 1);

  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               tick;
  fan_state_e         state_q, state_d;
  logic [ArmCntW-1:0] arm_cnt_q, arm_cnt_d;
  logic               period_tick_q;

  logic signed [31:0] pid  [4];
  logic [DutyW-1:0]   duty [4];

  assign tick  = (cnt_q == CntLast);
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    arm_cnt_d = arm_cnt_q;
    if (tick) begin
      unique case (state_q)
        StIdle: begin
          if (arm_i) begin
            state_d   = StArming;
            arm_cnt_d = '0;
          end
        end
        StArming: begin
          if (!arm_i) begin
            state_d = StIdle;
          end else begin
            arm_cnt_d = arm_cnt_q + 1'b1;
            if (arm_cnt_d == ArmCntW'(ArmPeriods)) state_d = StRun;
          end
        end
        StRun: begin
          if (!arm_i) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q         <= '0;
      state_q       <= StIdle;
      arm_cnt_q     <= '0;
      period_tick_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      arm_cnt_q     <= arm_cnt_d;
      period_tick_q <= (cnt_d == CntLast);
    end
  end

  assign pid[0] = pid_out1_i;
  assign pid[1] = pid_out2_i;
  assign pid[2] = pid_out3_i;
  assign pid[3] = pid_out4_i;

  for (genvar i = 0; i < 4; i++) begin : g_ch
    fan_pwm_channel #(
      .PwmPeriod (PwmPeriod),
      .DutyW     (DutyW),
      .RpmMax    (RpmMax),
      .DutyMul   (DutyMul),
      .SlewMax   (SlewMax),
      .ArmDuty   (ArmDuty),
      .CntW      (CntW)
    ) u_ch (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .tick_i       (tick),
      .cnt_next_i   (cnt_d),
      .state_next_i (state_d),
      .pid_i        (pid[i]),
      .duty_o       (duty[i]),
      .sat_o        (sat_o[i]),
      .pwm_o        (pwm_out_o[i])
    );
  end

  assign duty1_o       = duty[0];
  assign duty2_o       = duty[1];
  assign duty3_o       = duty[2];
  assign duty4_o       = duty[3];
  assign state_o       = state_q;
  assign period_tick_o = period_tick_q;

endmodule

// File: tb/tb_fan_pwm_driver.sv
// Directed bench for fan_pwm_driver: reset, arming, slew, saturation, disarm, async reset.
module tb_fan_pwm_driver;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               arm = 1'b0;
  logic signed [31:0] pid1 = 0, pid2 = 0, pid3 = 0, pid4 = 0;
  logic [3:0]         pwm_out;
  logic [10:0]        duty1, duty2, duty3, duty4;
  logic [3:0]         sat;
  logic [1:0]         state;
  logic               period_tick;

  logic [10:0] duty [4];
  int vectors = 0;
  int miscompares = 0;
  int hi [4];
  int ticks;

  assign duty[0] = duty1;
  assign duty[1] = duty2;
  assign duty[2] = duty3;
  assign duty[3] = duty4;

  always #5 clk = ~clk;

  fan_pwm_driver u_dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .arm_i         (arm),
    .pid_out1_i    (pid1),
    .pid_out2_i    (pid2),
    .pid_out3_i    (pid3),
    .pid_out4_i    (pid4),
    .pwm_out_o     (pwm_out),
    .duty1_o       (duty1),
    .duty2_o       (duty2),
    .duty3_o       (duty3),
    .duty4_o       (duty4),
    .sat_o         (sat),
    .state_o       (state),
    .period_tick_o (period_tick)
  );

  // Runs one full period from a counter=0 negedge, counting high cycles and ticks,
  // with optional mid-period input changes. Ends on the next counter=0 negedge.
  task automatic measure(input int pid_at, input int pid_val, input int disarm_at,
                         input int rearm_at);
    for (int ch = 0; ch < 4; ch++) hi[ch] = 0;
    ticks = 0;
    for (int c = 0; c < 1000; c++) begin
      for (int ch = 0; ch < 4; ch++) if (pwm_out[ch]) hi[ch]++;
      if (period_tick) ticks++;
      if (c == pid_at) begin
        pid1 = pid_val; pid2 = pid_val; pid3 = pid_val; pid4 = pid_val;
      end
      if (c == disarm_at) arm = 1'b0;
      if (c == rearm_at) arm = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic skip_period();
    repeat (1000) @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({pwm_out, sat, state, period_tick} !== 11'd0 || {duty1, duty2, duty3, duty4} !== 44'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got pwm=%b sat=%b state=%0d tick=%b duty=%0d/%0d/%0d/%0d required all 0",
               pwm_out, sat, state, period_tick, duty1, duty2, duty3, duty4);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int p = 0; p < 3; p++) begin
      vectors++;
      if (state !== 2'd0 || {duty1, duty2, duty3, duty4} !== 44'd0) begin
        miscompares++;
        $display("FAIL idle_state p%0d: got state=%0d duty1=%0d required state=0 duty=0", p, state, duty1);
      end
      measure(-1, 0, -1, -1);
      vectors++;
      if (hi[0] + hi[1] + hi[2] + hi[3] != 0) begin
        miscompares++;
        $display("FAIL idle_pwm p%0d: got %0d high cycles required 0", p, hi[0] + hi[1] + hi[2] + hi[3]);
      end
      vectors++;
      if (ticks != 1) begin
        miscompares++;
        $display("FAIL idle_tick p%0d: got %0d ticks required 1", p, ticks);
      end
    end
  endtask

  task automatic test_arming();
    pid1 = 5000; pid2 = 5000; pid3 = 5000; pid4 = 5000;
    arm = 1'b1;
    measure(-1, 0, -1, -1);
    vectors++;
    if (hi[0] != 0) begin
      miscompares++;
      $display("FAIL arm_wait_pwm: got %0d high required 0", hi[0]);
    end
    for (int p = 0; p < 4; p++) begin
      vectors++;
      if (state !== 2'd1) begin
        miscompares++;
        $display("FAIL arming_state p%0d: got %0d required 1", p, state);
      end
      for (int ch = 0; ch < 4; ch++) begin
        vectors++;
        if (int'(duty[ch]) !== 50) begin
          miscompares++;
          $display("FAIL arming_duty p%0d ch%0d: got %0d required 50", p, ch, duty[ch]);
        end
      end
      // A brief ARM drop between ticks must be ignored.
      if (p == 1) measure(-1, 0, 500, 505);
      else measure(-1, 0, -1, -1);
      for (int ch = 0; ch < 4; ch++) begin
        vectors++;
        if (hi[ch] != 50) begin
          miscompares++;
          $display("FAIL arming_pwm p%0d ch%0d: got %0d high required 50", p, ch, hi[ch]);
        end
      end
    end
    vectors++;
    if (state !== 2'd2) begin
      miscompares++;
      $display("FAIL run_entry_state: got %0d required 2", state);
    end
  endtask

  task automatic test_slew();
    for (int k = 0; k < 10; k++) begin
      int exp;
      exp = (k < 9) ? 100 + 50 * k : 500;
      for (int ch = 0; ch < 4; ch++) begin
        vectors++;
        if (int'(duty[ch]) !== exp) begin
          miscompares++;
          $display("FAIL slew_duty k%0d ch%0d: got %0d required %0d", k, ch, duty[ch], exp);
        end
      end
      measure(-1, 0, -1, -1);
      vectors++;
      if (hi[0] != exp || hi[3] != exp) begin
        miscompares++;
        $display("FAIL slew_pwm k%0d: got %0d/%0d high required %0d", k, hi[0], hi[3], exp);
      end
    end
  endtask

  task automatic test_saturation();
    pid1 = -3000; pid2 = 20000;
    for (int k = 1; k <= 10; k++) begin
      skip_period();
      vectors++;
      if (int'(duty1) !== 500 - 50 * k || int'(duty2) !== 500 + 50 * k || int'(duty3) !== 500) begin
        miscompares++;
        $display("FAIL sat_slew k%0d: got %0d/%0d/%0d required %0d/%0d/500",
                 k, duty1, duty2, duty3, 500 - 50 * k, 500 + 50 * k);
      end
      vectors++;
      if (sat !== 4'b0011) begin
        miscompares++;
        $display("FAIL sat_flags k%0d: got %b required 0011", k, sat);
      end
    end
    measure(-1, 0, -1, -1);
    vectors++;
    if (hi[0] != 0 || hi[1] != 1000 || hi[2] != 500) begin
      miscompares++;
      $display("FAIL sat_pwm: got %0d/%0d/%0d high required 0/1000/500", hi[0], hi[1], hi[2]);
    end
    pid1 = 5000; pid2 = 5000;
    skip_period();
    vectors++;
    if (sat !== 4'b0000 || int'(duty1) !== 50 || int'(duty2) !== 950) begin
      miscompares++;
      $display("FAIL sat_clear: got sat=%b duty=%0d/%0d required sat=0000 duty=50/950",
               sat, duty1, duty2);
    end
  endtask

  task automatic test_midperiod_disarm();
    measure(300, 0, 600, -1);
    vectors++;
    if (hi[0] != 50 || hi[1] != 950 || hi[2] != 500 || hi[3] != 500) begin
      miscompares++;
      $display("FAIL midperiod_pulse: got %0d/%0d/%0d/%0d high required 50/950/500/500",
               hi[0], hi[1], hi[2], hi[3]);
    end
    vectors++;
    if (state !== 2'd0 || {duty1, duty2, duty3, duty4} !== 44'd0) begin
      miscompares++;
      $display("FAIL disarm_state: got state=%0d duty2=%0d required state=0 duty=0", state, duty2);
    end
    measure(-1, 0, -1, -1);
    vectors++;
    if (hi[0] + hi[1] + hi[2] + hi[3] != 0) begin
      miscompares++;
      $display("FAIL disarm_pwm: got %0d high required 0", hi[0] + hi[1] + hi[2] + hi[3]);
    end
  endtask

  task automatic test_async_reset();
    int n;
    pid1 = -1; pid2 = 5000; pid3 = 5000; pid4 = 5000;
    arm = 1'b1;
    measure(-1, 0, -1, -1);
    repeat (4) skip_period();
    vectors++;
    if (state !== 2'd2 || int'(duty2) !== 100 || int'(duty1) !== 0 || sat !== 4'b0001) begin
      miscompares++;
      $display("FAIL rearm_run: got state=%0d duty1=%0d duty2=%0d sat=%b required 2/0/100/0001",
               state, duty1, duty2, sat);
    end
    repeat (400) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({pwm_out, sat, state, period_tick} !== 11'd0 || {duty1, duty2, duty3, duty4} !== 44'd0) begin
      miscompares++;
      $display("FAIL async_reset: got pwm=%b sat=%b state=%0d duty2=%0d required all 0",
               pwm_out, sat, state, duty2);
    end
    arm = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    vectors++;
    if (state !== 2'd0) begin
      miscompares++;
      $display("FAIL post_reset_state: got %0d required 0", state);
    end
    n = 0;
    while (!period_tick && n < 1100) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n != 999) begin
      miscompares++;
      $display("FAIL post_reset_counter: got first tick after %0d cycles required 999", n);
    end
  endtask

  initial begin
    test_reset();
    test_arming();
    test_slew();
    test_saturation();
    test_midperiod_disarm();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fan_pwm_driver.md
Name: fan_pwm_driver

Overview:
- Downstream stage of the mode FSM / PID controllers. Consumes the four signed PID outputs (PID_OUT1..4) and turns them into four glitch-free PWM motor-drive signals.
- Per channel: saturation, fixed-point scaling to duty, a per-period slew limiter, and a shared arm/spin-up state machine.
- All duty updates occur only at PWM period boundaries, so a mode change upstream never produces a runt pulse.

Parameters:
- PWM_PERIOD, 1000, clock cycles per PWM period (counter runs 0..PWM_PERIOD-1).
- DUTY_W, 11, duty width; must satisfy 2^DUTY_W > PWM_PERIOD.
- RPM_MAX, 10000, PID command mapped to 100% duty; upper saturation bound.
- DUTY_MUL, 6554, round(PWM_PERIOD*65536/RPM_MAX); scale multiplier.
- SLEW_MAX, 50, maximum change of applied duty per period, in counts.
- ARM_DUTY, 50, fixed duty held during spin-up.
- ARM_PERIODS, 4, number of full periods spent in ARMING.

Ports:
- CLK  in  1  system clock.
- nRST  in  1  asynchronous active-low reset.
- ARM  in  1  1 = motors enabled; sampled only at the period boundary.
- PID_OUT1..PID_OUT4  in  32 signed each  PID command per fan, in RPM units.
- PWM_OUT  out  4  registered PWM outputs; bit i-1 drives fan i.
- DUTY1..DUTY4  out  DUTY_W each  applied duty of the current period.
- SAT  out  4  bit i-1 = fan i command was clamped at the last boundary.
- STATE  out  2  0 IDLE, 1 ARMING, 2 RUN.
- PERIOD_TICK  out  1  one-cycle pulse when the counter equals PWM_PERIOD-1.

Behaviour:
- Reset (nRST low, asynchronous): counter=0, STATE=IDLE, DUTY1..4=0, PWM_OUT=0, SAT=0, PERIOD_TICK=0, arm-period counter=0.
- Period counter:
  - Free-running 0..PWM_PERIOD-1, wraps to 0.
  - Runs in every state.
  - PERIOD_TICK is registered and high during the cycle in which the counter is PWM_PERIOD-1.
- Boundary ("tick") = the clock edge on which the counter wraps to 0. All state, duty and SAT updates happen only at this edge. New values take effect from counter=0.
- Per-channel command path, evaluated at each tick:
  - Saturate: s = 0 if PID_OUT<0; s = RPM_MAX if PID_OUT>RPM_MAX; else s = PID_OUT.
  - SAT[i] = 1 iff clamping occurred.
  - Target T = (s*DUTY_MUL)>>16, computed at full product width, then clamped to PWM_PERIOD.
- FSM, with transitions at the tick only:
  - IDLE: applied duty=0. If ARM=1 go to ARMING, clear the arm counter.
  - ARMING: applied duty=ARM_DUTY on all channels. The arm counter increments each tick. After ARM_PERIODS ticks go to RUN. ARM=0 at a tick returns to IDLE.
  - RUN: applied duty A moves toward T by min(|T-A|, SLEW_MAX); A=T when within the step. ARM=0 at a tick goes to IDLE with A=0 immediately, with no slew on the way down.
  - Entering RUN, A starts from ARM_DUTY.
  - ARM changes between ticks are ignored.
- PWM_OUT[i] is a register: on each edge it loads (next counter value < applied duty for that period).
  - Duty 0 gives a constant low output.
  - Duty PWM_PERIOD gives a constant high output.
  - The output is aligned to the counter, with the high phase starting at counter=0.
- PID_OUT may change every cycle; only the value present at the tick edge is used.
- Reset mid-period aborts the period immediately. All outputs return to reset values and the next period starts at counter=0 after release.

Decomposition:
- Shared package:
  - State enum (IDLE/ARMING/RUN) and its 2-bit encoding.
  - Default constants for PWM_PERIOD, RPM_MAX, DUTY_MUL, SLEW_MAX, ARM_DUTY, ARM_PERIODS.
- Sub-module fan_pwm_channel, instantiated 4x. It owns saturation, scaling, the slew register and the output compare. It takes the shared counter, tick, and FSM state as inputs.
- The top level owns the counter, the FSM and the arm counter.

Test Plan:
- Reset/idle: hold nRST=0 for 3 cycles, release, ARM=0 for 3 periods -> PWM_OUT=0, DUTY=0, STATE=0, exactly one PERIOD_TICK every 1000 cycles.
- Arming: ARM=1, PID_OUT=5000 -> STATE=1 after the next tick, DUTY=50 (PWM high 50 cycles/period) for 4 periods, then STATE=2.
- Slew: continuing from the arming scenario, T=500 -> DUTY sequence 100,150,...,500 on successive periods, then steady 500 (high exactly 500 cycles).
- Saturation: PID_OUT1=-3000, PID_OUT2=20000 in RUN at target -> DUTY1 slews down to 0 and DUTY2 slews up to 1000 (constant high), SAT=4'b0011. PID_OUT back to 5000 -> SAT clears at the next tick.
- Mid-period change/disarm: change PID_OUT at counter=300 and drop ARM at counter=600 -> the current pulse is unchanged, STATE=0 and DUTY=0 from the next counter=0.
- Async reset in RUN at counter=400 -> all outputs 0 within the same cycle, no clock edge needed. After release, STATE=0 and the counter restarts at 0.
